fifo_mem_sequencer: RTL

FIFO_MEM_SEQUENCER -- requirements
Module: fifo_mem_sequencer

---
 rtl/fifo_seq_pkg.sv | 19 +
 rtl/fifo_seq_ptr.sv | 44 ++++
 rtl/fifo_mem_sequencer.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/fifo_seq_pkg.sv
// Shared types for the FIFO memory sequencer: memory command codes and controller states.
package fifo_seq_pkg;

   typedef enum logic [1:0] {
      RWC_IDLE   = 2'd0,
      RWC_WRITE  = 2'd1,
      RWC_READ   = 2'd2,
      RWC_BYPASS = 2'd3
   } rwc_e;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_WR   = 3'd1,
      ST_RD   = 3'd2,
      ST_BYP  = 3'd3,
      ST_OUT  = 3'd4
   } state_e;

endpackage

// File: rtl/fifo_seq_ptr.sv
// Write/read pointers and occupancy for the FIFO memory sequencer.
// Pointers wrap naturally because DEPTH is a power of two.
module fifo_seq_ptr #(
   parameter int DEPTH = 1024,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          inc_wr,
   input  logic          inc_rd,
   output logic [AW-1:0] wr_ptr,
   output logic [AW-1:0] rd_ptr,
   output logic [AW:0]   count,
   output logic          full,
   output logic          empty
);

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic wr_ok;
   logic rd_ok;

   assign full  = (count == FULL_CNT);
   assign empty = (count == '0);
   assign wr_ok = inc_wr && !full;
   assign rd_ok = inc_rd && !empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
         if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_ok, rd_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/fifo_mem_sequencer.sv
// FIFO built on an external dual-port memory, one memory command in flight at a time.
// Define FIFO_SEQ_BYPASS_EN to route data arriving at an empty FIFO through the BYP path.
//
// state | meaning
// IDLE  | choose next command (bypass, read, write) or wait
// WR    | write held data at wr_ptr until mem_wready
// RD    | read at rd_ptr until mem_rvalid, capture to out_data
// BYP   | write held data, then read it back at the same address
// OUT   | present out_data until out_ready
import fifo_seq_pkg::*;

module fifo_mem_sequencer #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 1024,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [1:0]       mem_rwc,
   output logic [AW-1:0]    mem_wa,
   output logic [AW-1:0]    mem_ra,
   output logic [WIDTH-1:0] mem_wdata,
   output logic             mem_wvalid,
   input  logic             mem_wready,
   input  logic [WIDTH-1:0] mem_rdata,
   input  logic             mem_rvalid,
   output logic             mem_rready,
   output logic [AW:0]      count,
   output logic             full,
   output logic             empty
);

   state_e           state, state_nxt;
   rwc_e             rwc;
   logic             byp_wdone, byp_wdone_nxt;
   logic [WIDTH-1:0] hold_data;
   logic [WIDTH-1:0] out_data_q;
   logic             inc_wr, inc_rd;
   logic             capture_in, capture_out;

   fifo_seq_ptr #(.DEPTH(DEPTH), .AW(AW)) u_ptr (
      .clk    (clk),
      .rst_n  (rst_n),
      .inc_wr (inc_wr),
      .inc_rd (inc_rd),
      .wr_ptr (mem_wa),
      .rd_ptr (mem_ra),
      .count  (count),
      .full   (full),
      .empty  (empty)
   );

   assign mem_rwc   = rwc;
   assign mem_wdata = hold_data;
   assign out_data  = out_data_q;

   always_comb begin
      state_nxt     = state;
      byp_wdone_nxt = byp_wdone;
      rwc           = RWC_IDLE;
      inc_wr        = 1'b0;
      inc_rd        = 1'b0;
      capture_in    = 1'b0;
      capture_out   = 1'b0;
      in_ready      = 1'b0;
      out_valid     = 1'b0;
      mem_wvalid    = 1'b0;
      mem_rready    = 1'b0;
      case (state)
         ST_IDLE: begin
`ifdef FIFO_SEQ_BYPASS_EN
            if (empty && in_valid && out_ready) begin
               state_nxt     = ST_BYP;
               capture_in    = 1'b1;
               byp_wdone_nxt = 1'b0;
            end else
`endif
            if (!empty && out_ready) begin
               state_nxt = ST_RD;
            end else if (in_valid && !full) begin
               state_nxt  = ST_WR;
               capture_in = 1'b1;
            end
            in_ready = capture_in;
         end
         ST_WR: begin
            rwc        = RWC_WRITE;
            mem_wvalid = 1'b1;
            if (mem_wready) begin
               inc_wr    = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         ST_RD: begin
            rwc        = RWC_READ;
            mem_rready = 1'b1;
            if (mem_rvalid) begin
               capture_out = 1'b1;
               inc_rd      = 1'b1;
               state_nxt   = ST_OUT;
            end
         end
         ST_BYP: begin
            // Empty FIFO: wr_ptr == rd_ptr, so the read-back returns the word just written.
            rwc = RWC_BYPASS;
            if (!byp_wdone) begin
               mem_wvalid = 1'b1;
               if (mem_wready) byp_wdone_nxt = 1'b1;
            end else begin
               mem_rready = 1'b1;
               if (mem_rvalid) begin
                  capture_out   = 1'b1;
                  byp_wdone_nxt = 1'b0;
                  state_nxt     = ST_OUT;
               end
            end
         end
         ST_OUT: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         byp_wdone  <= 1'b0;
         hold_data  <= '0;
         out_data_q <= '0;
      end else begin
         state     <= state_nxt;
         byp_wdone <= byp_wdone_nxt;
         if (capture_in)  hold_data  <= in_data;
         if (capture_out) out_data_q <= mem_rdata;
      end
   end

endmodule
